spi_target: RTL and testbench
=============================

Name: spi_target

Overview:
- SPI target (peripheral) endpoint: the far end of the team's SPI controller that generates sclk.
- Oversamples the external sclk, cs_n and mosi on the system clock.
- Shifts a DATA_WIDTH-bit word in on mosi and out on miso in all four CPOL/CPHA modes.
- Presents received words and accepts transmit words through one-word handshakes to the local fabric.

Parameters:
- DATA_WIDTH, 8: bits per SPI word. Legal range 4..32.
- SYNC_STAGES, 2: flops per input synchronizer on sclk, cs_n and mosi. Minimum 2.

Ports:
- clk  in  1  system clock; must be at least 8x the sclk frequency.
- async_rst_n  in  1  asynchronous active-low reset.
- clk_en  in  1  global clock enable; all state, synchronizers included, holds when low.
- configure  in  1  latch cpol_in/cpha_in; honoured only while deselected.
- cpol_in  in  1  sclk idle level.
- cpha_in  in  1  0 = sample on leading edge; 1 = sample on trailing edge.
- sclk  in  1  asynchronous serial clock from the controller.
- cs_n  in  1  asynchronous active-low chip select.
- mosi  in  1  serial data in.
- miso  out  1  serial data out.
- miso_oe  out  1  miso output enable; high while selected.
- tx_data  in  DATA_WIDTH  next word to transmit.
- tx_valid  in  1  tx_data is available.
- tx_ready  out  1  one-cycle pulse: tx_data consumed this cycle.
- tx_underrun  out  1  one-cycle pulse: word load occurred with tx_valid low.
- rx_data  out  DATA_WIDTH  last completed received word; held until the next completion.
- rx_valid  out  1  one-cycle pulse: rx_data updated.
- word_abort  out  1  one-cycle pulse: cs_n rose mid-word.

Behaviour:
- Reset, async, active-low:
  - cpol=0, cpha=0, state IDLE.
  - miso=0, miso_oe=0, tx_ready=0, tx_underrun=0, rx_valid=0, word_abort=0, rx_data=0.
  - Bit counter 0; synchronizers load sclk=0, cs_n=1, mosi=0.
- Input capture and edge detection:
  - Inputs pass through SYNC_STAGES flops plus one history flop.
  - Edge detect = last stage vs history; a pin transition is seen SYNC_STAGES+1 enabled cycles later.
  - Leading edge = sclk leaving its cpol level. Trailing edge = sclk returning to it.
- States:
  - IDLE: cs_n synced high.
  - LOAD: single cycle after cs_n synced falls.
  - ACTIVE: until cs_n rises.
- Configuration: configure with clk_en high in IDLE latches cpol/cpha on the next edge. In LOAD or ACTIVE it is ignored.
- Word load, from LOAD or at a word boundary:
  - tx_valid high: shift_out <= tx_data, pulse tx_ready.
  - tx_valid low: shift_out <= 0, pulse tx_underrun.
  - miso = the first-order bit of shift_out (MSB by default) whenever miso_oe is high; 0 otherwise.
- CPHA=0:
  - Sample mosi on every leading edge; shift_out advances on every trailing edge.
  - The trailing edge following the DATA_WIDTH-th sample performs a word load instead of a shift.
- CPHA=1:
  - First leading edge after LOAD does nothing; later leading edges shift, or word-load at a boundary.
  - Sample mosi on every trailing edge.
- Word completion:
  - On the DATA_WIDTH-th sample, rx_data <= completed word in the cycle after the edge detect, with rx_valid pulsed that same cycle.
  - Bit counter wraps to 0.
  - Back-to-back words require no gap.
- cs_n rises mid-word (counter non-zero):
  - Partial word discarded; word_abort pulses; rx_data unchanged.
  - Go to IDLE; counter cleared; miso_oe drops the cycle cs_n synced rises.
- cs_n rises at a word boundary: IDLE, no pulse.
- Edge and cs_n change detected in the same cycle: cs_n wins, and the edge is discarded.
- clk_en low: no state change; outputs hold; pulses remain one enabled cycle long.

Optional Feature:
- Macro SPI_TARGET_LSB_FIRST_EN.
- Defined: adds input lsb_first_in (1 bit), latched with configure (reset 0). When the latched value is 1, miso sends bit 0 first and mosi fills from the MSB downward, so rx_data bit order matches the wire order LSB-first.
- Undefined: no port; MSB-first always.

Test Plan:
- Reset, configure mode 0, tx_data=0x3C with tx_valid, controller sends 0xA5 -> miso bits 0,0,1,1,1,1,0,0; rx_data=0xA5 with one rx_valid pulse; one tx_ready pulse at LOAD.
- Mode 3 (cpol=1, cpha=1), tx 0x81 then 0x7E back-to-back with cs_n held low, controller sends 0xF0,0x0F -> miso 0x81 then 0x7E; rx_valid twice with 0xF0 then 0x0F; two tx_ready pulses.
- Mode 1, tx_valid low -> tx_underrun pulse at LOAD, miso all zeros, rx still completes.
- cs_n raised after 5 bits in mode 2 -> word_abort pulse, no rx_valid, rx_data keeps previous 0xA5, miso_oe low.
- configure to mode 3 while cs_n low, mid-word -> ignored, word completes as mode 0; the same configure in IDLE takes effect for the next word.
- async_rst_n pulsed low mid-word -> all outputs at reset values immediately, no rx_valid; next full transfer succeeds in mode 0.

Source files
------------

// File: rtl/spi_target.sv
// SPI target endpoint: oversampled sclk/cs_n/mosi, all four CPOL/CPHA modes, one-word handshakes.
// Optional LSB-first support is enabled by defining SPI_TARGET_LSB_FIRST_EN.
module spi_target #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  async_rst_n,
  input  logic                  clk_en,
  input  logic                  configure,
  input  logic                  cpol_in,
  input  logic                  cpha_in,
`ifdef SPI_TARGET_LSB_FIRST_EN
  input  logic                  lsb_first_in,
`endif
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_underrun,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  word_abort
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StActive} state_e;

  state_e state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, cs_sync_q, cs_sync_d, mosi_sync_q, mosi_sync_d;
  logic sclk_hist_q, sclk_hist_d;
  logic cpol_q, cpol_d, cpha_q, cpha_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_in_q, shift_in_d, shift_out_q, shift_out_d, rx_data_q, rx_data_d;
  logic [DATA_WIDTH-1:0] in_next;
  logic load_pend_q, load_pend_d, skip_q, skip_d;
  logic rx_valid_q, rx_valid_d, tx_ready_q, tx_ready_d;
  logic tx_underrun_q, tx_underrun_d, word_abort_q, word_abort_d;
  logic sclk_s, cs_s, mosi_s, lead_edge, trail_edge, sample_edge, shift_edge;
  logic load_word, shift_word, lsb_first;

`ifdef SPI_TARGET_LSB_FIRST_EN
  logic lsb_first_q, lsb_first_d;
  assign lsb_first = lsb_first_q;
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n)  lsb_first_q <= 1'b0;
    else if (clk_en)   lsb_first_q <= lsb_first_d;
  end
  always_comb begin
    lsb_first_d = lsb_first_q;
    if (state_q == StIdle && configure) lsb_first_d = lsb_first_in;
  end
`else
  assign lsb_first = 1'b0;
`endif

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Leading edge leaves the idle level; trailing edge returns to it.
  assign lead_edge   = cpol_q ? (~sclk_s & sclk_hist_q) : (sclk_s & ~sclk_hist_q);
  assign trail_edge  = cpol_q ? (sclk_s & ~sclk_hist_q) : (~sclk_s & sclk_hist_q);
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;

  assign in_next = lsb_first ? {mosi_s, shift_in_q[DATA_WIDTH-1:1]}
                             : {shift_in_q[DATA_WIDTH-2:0], mosi_s};

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q <= StIdle;
    end else if (clk_en) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (!cs_s) state_d = StLoad;
      StLoad:   state_d = cs_s ? StIdle : StActive;
      StActive: if (cs_s) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    miso_oe = (state_q != StIdle) && !cs_s;
    miso    = miso_oe & (lsb_first ? shift_out_q[0] : shift_out_q[DATA_WIDTH-1]);
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      sclk_sync_q   <= '0;
      cs_sync_q     <= '1;
      mosi_sync_q   <= '0;
      sclk_hist_q   <= 1'b0;
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
      cnt_q         <= '0;
      shift_in_q    <= '0;
      shift_out_q   <= '0;
      rx_data_q     <= '0;
      load_pend_q   <= 1'b0;
      skip_q        <= 1'b0;
      rx_valid_q    <= 1'b0;
      tx_ready_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      word_abort_q  <= 1'b0;
    end else if (clk_en) begin
      sclk_sync_q   <= sclk_sync_d;
      cs_sync_q     <= cs_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      sclk_hist_q   <= sclk_hist_d;
      cpol_q        <= cpol_d;
      cpha_q        <= cpha_d;
      cnt_q         <= cnt_d;
      shift_in_q    <= shift_in_d;
      shift_out_q   <= shift_out_d;
      rx_data_q     <= rx_data_d;
      load_pend_q   <= load_pend_d;
      skip_q        <= skip_d;
      rx_valid_q    <= rx_valid_d;
      tx_ready_q    <= tx_ready_d;
      tx_underrun_q <= tx_underrun_d;
      word_abort_q  <= word_abort_d;
    end
  end

  always_comb begin
    sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_hist_d   = sclk_s;
    cpol_d        = cpol_q;
    cpha_d        = cpha_q;
    cnt_d         = cnt_q;
    shift_in_d    = shift_in_q;
    shift_out_d   = shift_out_q;
    rx_data_d     = rx_data_q;
    load_pend_d   = load_pend_q;
    skip_d        = skip_q;
    rx_valid_d    = 1'b0;
    tx_ready_d    = 1'b0;
    tx_underrun_d = 1'b0;
    word_abort_d  = 1'b0;
    load_word     = 1'b0;
    shift_word    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (configure) begin
          cpol_d = cpol_in;
          cpha_d = cpha_in;
        end
      end
      StLoad: begin
        cnt_d       = '0;
        load_pend_d = 1'b0;
        skip_d      = cpha_q;
        load_word   = ~cs_s;
      end
      StActive: begin
        // Deselect takes priority; any sclk edge seen in the same cycle is dropped.
        if (cs_s) begin
          word_abort_d = (cnt_q != '0);
          cnt_d        = '0;
          load_pend_d  = 1'b0;
          skip_d       = 1'b0;
        end else begin
          if (sample_edge) begin
            shift_in_d = in_next;
            if (cnt_q == LastBit) begin
              cnt_d       = '0;
              rx_data_d   = in_next;
              rx_valid_d  = 1'b1;
              load_pend_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          if (shift_edge) begin
            if (skip_q) begin
              skip_d = 1'b0;
            end else if (load_pend_q) begin
              load_word   = 1'b1;
              load_pend_d = 1'b0;
            end else begin
              shift_word = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
    if (load_word) begin
      shift_out_d   = tx_valid ? tx_data : '0;
      tx_ready_d    = tx_valid;
      tx_underrun_d = ~tx_valid;
    end else if (shift_word) begin
      shift_out_d = lsb_first ? (shift_out_q >> 1) : (shift_out_q << 1);
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ready    = tx_ready_q;
  assign tx_underrun = tx_underrun_q;
  assign word_abort  = word_abort_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: bus-functional SPI controller plus per-scenario checks.
module tb_spi_target;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic async_rst_n = 1'b0;
  logic clk_en = 1'b1;
  logic configure = 1'b0, cpol_in = 1'b0, cpha_in = 1'b0;
  logic sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic miso, miso_oe;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0;
  logic tx_ready, tx_underrun, rx_valid, word_abort;
  logic [7:0] rx_data;

  int tests_run = 0, tests_failed = 0;
  int rx_cnt = 0, ready_cnt = 0, unr_cnt = 0, abort_cnt = 0;
  logic [7:0] rx_log [0:15];
  logic [7:0] miso_word;
  logic cpol_t = 1'b0, cpha_t = 1'b0;

  spi_target #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .async_rst_n(async_rst_n), .clk_en(clk_en), .configure(configure),
    .cpol_in(cpol_in), .cpha_in(cpha_in), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_underrun(tx_underrun), .rx_data(rx_data),
    .rx_valid(rx_valid), .word_abort(word_abort)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[rx_cnt % 16] = rx_data;
      rx_cnt++;
    end
    if (tx_ready) ready_cnt++;
    if (tx_underrun) unr_cnt++;
    if (word_abort) abort_cnt++;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mode(input logic pol, input logic pha);
    sclk = pol; cpol_t = pol; cpha_t = pha;
    cpol_in = pol; cpha_in = pha;
    configure = 1'b1; wait_clks(1); configure = 1'b0;
    wait_clks(8);
  endtask

  // Controller drives bits hi..lo of w and records miso into miso_word.
  task automatic spi_bits(input logic [7:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      if (!cpha_t) begin
        mosi = w[i]; wait_clks(HALF);
        sclk = ~cpol_t; miso_word[i] = miso; wait_clks(HALF);
        sclk = cpol_t;
      end else begin
        wait_clks(HALF);
        sclk = ~cpol_t; mosi = w[i]; wait_clks(HALF);
        sclk = cpol_t; miso_word[i] = miso;
      end
    end
  endtask

  task automatic wait_ready(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (tx_ready) seen = 1'b1;
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL %s: tx_ready seen=%0d, required 1", name, seen);
    end
  endtask

  task automatic feed(input logic [7:0] a, input logic [7:0] b, input int n);
    tx_data = a; tx_valid = 1'b1;
    wait_ready("feed_first");
    if (n > 1) begin
      tx_data = b;
      wait_ready("feed_second");
    end
    tx_valid = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  task automatic test_reset;
    chk("reset_miso", {31'd0, miso}, 32'd0);
    chk("reset_miso_oe", {31'd0, miso_oe}, 32'd0);
    chk("reset_tx_ready", {31'd0, tx_ready}, 32'd0);
    chk("reset_tx_underrun", {31'd0, tx_underrun}, 32'd0);
    chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset_word_abort", {31'd0, word_abort}, 32'd0);
    chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
  endtask

  task automatic test_mode0;
    int r0 = rx_cnt, t0 = ready_cnt, a0 = abort_cnt;
    set_mode(1'b0, 1'b0);
    cs_n = 1'b0;
    fork
      feed(8'h3C, 8'h00, 1);
      begin wait_clks(4); chk("m0_miso_oe_sel", {31'd0, miso_oe}, 32'd1); spi_bits(8'hA5, 7, 0); end
    join
    wait_clks(HALF); cs_n = 1'b1; wait_clks(6);
    chk("m0_miso", {24'd0, miso_word}, 32'h3C);
    chk("m0_rx_cnt", rx_cnt - r0, 1);
    chk("m0_rx_data", {24'd0, rx_log[r0 % 16]}, 32'hA5);
    chk("m0_tx_ready_cnt", ready_cnt - t0, 1);
    chk("m0_no_abort", abort_cnt - a0, 0);
    chk("m0_miso_oe_idle", {31'd0, miso_oe}, 32'd0);
  endtask

  task automatic test_abort;
    int r0 = rx_cnt, a0 = abort_cnt;
    set_mode(1'b1, 1'b0);
    cs_n = 1'b0;
    spi_bits(8'hFF, 7, 3);
    wait_clks(HALF); cs_n = 1'b1; wait_clks(6);
    chk("ab_abort_cnt", abort_cnt - a0, 1);
    chk("ab_no_rx", rx_cnt - r0, 0);
    chk("ab_rx_data_kept", {24'd0, rx_data}, 32'hA5);
    chk("ab_miso_oe", {31'd0, miso_oe}, 32'd0);
  endtask

  task automatic test_back_to_back;
    int r0 = rx_cnt, t0 = ready_cnt;
    logic [7:0] m1;
    set_mode(1'b1, 1'b1);
    cs_n = 1'b0;
    fork
      feed(8'h81, 8'h7E, 2);
      begin
        spi_bits(8'hF0, 7, 0); m1 = miso_word;
        spi_bits(8'h0F, 7, 0);
      end
    join
    wait_clks(HALF); cs_n = 1'b1; wait_clks(6);
    chk("b2b_miso_w0", {24'd0, m1}, 32'h81);
    chk("b2b_miso_w1", {24'd0, miso_word}, 32'h7E);
    chk("b2b_rx_cnt", rx_cnt - r0, 2);
    chk("b2b_rx_w0", {24'd0, rx_log[r0 % 16]}, 32'hF0);
    chk("b2b_rx_w1", {24'd0, rx_log[(r0 + 1) % 16]}, 32'h0F);
    chk("b2b_tx_ready_cnt", ready_cnt - t0, 2);
  endtask

  task automatic test_underrun;
    int r0 = rx_cnt, u0 = unr_cnt, t0 = ready_cnt;
    set_mode(1'b0, 1'b1);
    tx_valid = 1'b0;
    cs_n = 1'b0;
    spi_bits(8'h5A, 7, 0);
    wait_clks(HALF); cs_n = 1'b1; wait_clks(6);
    chk("ur_underrun_cnt", unr_cnt - u0, 1);
    chk("ur_miso", {24'd0, miso_word}, 32'h00);
    chk("ur_rx_cnt", rx_cnt - r0, 1);
    chk("ur_rx_data", {24'd0, rx_log[r0 % 16]}, 32'h5A);
    chk("ur_no_tx_ready", ready_cnt - t0, 0);
  endtask

  task automatic test_configure;
    int r0 = rx_cnt;
    set_mode(1'b0, 1'b0);
    cs_n = 1'b0;
    fork
      feed(8'h96, 8'h00, 1);
      begin
        spi_bits(8'hC3, 7, 4);
        cpol_in = 1'b1; cpha_in = 1'b1; configure = 1'b1; wait_clks(1); configure = 1'b0;
        spi_bits(8'hC3, 3, 0);
      end
    join
    wait_clks(HALF); cs_n = 1'b1; wait_clks(6);
    chk("cfg_busy_miso", {24'd0, miso_word}, 32'h96);
    chk("cfg_busy_rx", {24'd0, rx_log[r0 % 16]}, 32'hC3);
    set_mode(1'b1, 1'b1);
    cs_n = 1'b0;
    fork
      feed(8'h69, 8'h00, 1);
      spi_bits(8'h3C, 7, 0);
    join
    wait_clks(HALF); cs_n = 1'b1; wait_clks(6);
    chk("cfg_idle_miso", {24'd0, miso_word}, 32'h69);
    chk("cfg_idle_rx", {24'd0, rx_log[(r0 + 1) % 16]}, 32'h3C);
    chk("cfg_rx_cnt", rx_cnt - r0, 2);
  endtask

  task automatic test_reset_midword;
    int r0;
    cs_n = 1'b0;
    spi_bits(8'hAA, 7, 5);
    r0 = rx_cnt;
    #3 async_rst_n = 1'b0;
    #1;
    chk("rst_mid_miso_oe", {31'd0, miso_oe}, 32'd0);
    chk("rst_mid_miso", {31'd0, miso}, 32'd0);
    chk("rst_mid_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst_mid_rx_valid", {31'd0, rx_valid}, 32'd0);
    cs_n = 1'b1; sclk = 1'b0; cpol_t = 1'b0; cpha_t = 1'b0;
    wait_clks(2);
    async_rst_n = 1'b1;
    wait_clks(10);
    chk("rst_mid_no_rx", rx_cnt - r0, 0);
    cs_n = 1'b0;
    fork
      feed(8'h5A, 8'h00, 1);
      spi_bits(8'hC6, 7, 0);
    join
    wait_clks(HALF); cs_n = 1'b1; wait_clks(6);
    chk("rst_after_miso", {24'd0, miso_word}, 32'h5A);
    chk("rst_after_rx_cnt", rx_cnt - r0, 1);
    chk("rst_after_rx_data", {24'd0, rx_data}, 32'hC6);
  endtask

  initial begin
    wait_clks(3);
    async_rst_n = 1'b1;
    wait_clks(5);
    test_reset();
    test_mode0();
    test_abort();
    test_back_to_back();
    test_underrun();
    test_configure();
    test_reset_midword();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
